ssp_frame_master: RTL

Avalon-MM slave that acts as the initiator end of the 16-bit SSP register-access protocol spoken by the UART's SSP port. Each Avalon read or write becomes one serial SSP frame on SSP_SCK, SSP_SSEL and SSP_MOSI, with the response captured from SSP_MISO. It lets the HPS/Nios bus reach an SSP_UART located off-chip or in another clock region over four wires.

---
 rtl/ssp_frame_master_pkg.sv | 10 +
 rtl/ssp_sck_tick.sv | 20 ++
 rtl/ssp_frame_master.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ssp_frame_master_pkg.sv
// Shared definitions for the SSP frame master: FSM states and 16-bit frame field positions.
package ssp_master_pkg;
  localparam int unsigned SSP_FRAME_W = 16;
  localparam int unsigned RA_MSB      = 15;
  localparam int unsigned RA_LSB      = 13;
  localparam int unsigned WNR_BIT     = 12;
  localparam int unsigned DI_MSB      = 11;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} sspState_t;
endpackage

// File: rtl/ssp_sck_tick.sv
// Half-period counter for the SSP serial clock: pulses oTick once every pDiv+1 enabled cycles.
module ssp_sck_tick #(
  parameter logic [7:0] pDiv = 8'd1
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iEnable,
  input  logic iClear,
  output logic oTick
);
  logic [7:0] cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)      cnt <= '0;
    else if (iClear)  cnt <= '0;
    else if (iEnable) cnt <= (cnt == pDiv) ? '0 : cnt + 8'd1;
  end

  assign oTick = iEnable && !iClear && (cnt == pDiv);
endmodule

// File: rtl/ssp_frame_master.sv
// Avalon-MM slave turning each read/write into one 16-bit SSP frame (SCK/SSEL/MOSI/MISO).
// Build option: define SSP_FRAME_MASTER_LOOPBACK_EN to receive the registered MOSI instead of MISO.
module ssp_frame_master
  import ssp_master_pkg::*;
#(
  parameter logic [7:0]  pDiv       = 8'd1,
  parameter int unsigned pFrameBits = 16
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iChipSelect,
  input  logic        iWrite,
  input  logic        iRead,
  input  logic [2:0]  iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oWaitRequest,
  output logic        SSP_SCK,
  output logic        SSP_SSEL,
  output logic        SSP_MOSI,
  input  logic        SSP_MISO
);
  sspState_t state, stateNext;
  logic       phaseLow, phaseLowNext;
  logic [3:0] bitCnt, bitCntNext;
  logic       tick, tickEn, tickClr;
  logic       request, riseEv, fallEv;
  logic       lost, isRead, rxIn;
  logic [SSP_FRAME_W-1:0] txFrame, txShift, rxShift;
  logic       unusedBits;

  assign request      = iChipSelect && (iWrite || iRead);
  assign oWaitRequest = request && (state != DONE);
  assign tickEn       = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign tickClr      = !tickEn;

`ifdef SSP_FRAME_MASTER_LOOPBACK_EN
  assign rxIn       = SSP_MOSI;
  assign unusedBits = ^{iData[31:DI_MSB+1], rxShift[SSP_FRAME_W-1:DI_MSB+1], SSP_MISO};
`else
  assign rxIn       = SSP_MISO;
  assign unusedBits = ^{iData[31:DI_MSB+1], rxShift[SSP_FRAME_W-1:DI_MSB+1]};
`endif

  ssp_sck_tick #(.pDiv(pDiv)) uTick (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iEnable (tickEn),
    .iClear  (tickClr),
    .oTick   (tick)
  );

  always_comb begin
    txFrame                  = '0;
    txFrame[RA_MSB:RA_LSB]   = iAddress;
    txFrame[WNR_BIT]         = iWrite;
    if (iWrite) txFrame[DI_MSB:0] = iData[DI_MSB:0];
  end

  always_comb begin
    stateNext    = state;
    phaseLowNext = phaseLow;
    bitCntNext   = bitCnt;
    riseEv       = 1'b0;
    fallEv       = 1'b0;
    case (state)
      IDLE: if (request) begin
        stateNext  = SETUP;
        bitCntNext = 4'(pFrameBits - 1);
      end
      SETUP: if (tick) begin
        stateNext    = SHIFT;
        phaseLowNext = 1'b0;
        riseEv       = 1'b1;
      end
      // Each bit: high phase then low phase; the next rising edge starts the next bit.
      SHIFT: if (tick) begin
        if (!phaseLow) begin
          phaseLowNext = 1'b1;
          fallEv       = 1'b1;
        end else if (bitCnt == 4'd0) begin
          stateNext = HOLD;
        end else begin
          bitCntNext   = bitCnt - 4'd1;
          phaseLowNext = 1'b0;
          riseEv       = 1'b1;
        end
      end
      HOLD: if (tick) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= IDLE;
      phaseLow <= 1'b0;
      bitCnt   <= '0;
    end else begin
      state    <= stateNext;
      phaseLow <= phaseLowNext;
      bitCnt   <= bitCntNext;
    end
  end

  // Serial outputs are registered from the next-state view so they line up with the state.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      SSP_SCK  <= 1'b0;
      SSP_SSEL <= 1'b0;
      SSP_MOSI <= 1'b0;
      oData    <= '0;
      txShift  <= '0;
      rxShift  <= '0;
      lost     <= 1'b0;
      isRead   <= 1'b0;
    end else begin
      SSP_SSEL <= (stateNext == SETUP) || (stateNext == SHIFT) || (stateNext == HOLD);
      SSP_SCK  <= (stateNext == SHIFT) && !phaseLowNext;
      if (state == IDLE && request) begin
        txShift  <= txFrame;
        SSP_MOSI <= txFrame[SSP_FRAME_W-1];
        isRead   <= !iWrite;
        lost     <= 1'b0;
      end else if (fallEv) begin
        txShift  <= txShift << 1;
        SSP_MOSI <= txShift[SSP_FRAME_W-2];
      end
      if (tickEn && !request) lost <= 1'b1;
      if (riseEv) rxShift <= {rxShift[SSP_FRAME_W-2:0], rxIn};
      // Loaded on entry to DONE so readdata is valid while waitrequest is low.
      if (state == HOLD && tick && isRead && !lost && request)
        oData <= 32'(rxShift[DI_MSB:0]);
    end
  end
endmodule
